fp_mul_normalize_round: RTL
===========================

// Module: fp_mul_normalize_round
// PURPOSE
//  Sequential post-multiply stage for IEEE-754 single precision.
//  - Input: raw sign, raw biased-exponent sum and full 48-bit significand product (hidden bits included).
//  - Function: normalizes, rounds to nearest-even, saturates overflow/underflow, emits a packed 32-bit result.
//  - Position: between the FP multiplier datapath and the result consumer; valid/ready on both sides.
// PARAMETERS
//  EXP_W   8    exponent field width
//  FRAC_W  23   fraction field width; product width P = 2*(FRAC_W+1) = 48
//  BIAS    127  exponent bias
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        asynchronous reset, active low
//  in_valid       in   1        input operands valid
//  in_ready       out  1        block can accept (high only in IDLE)
//  in_sign        in   1        result sign (sign1 ^ sign2)
//  in_exp_sum     in   EXP_W+1  exp1 + exp2, biased fields, range 0..510
//  in_mant        in   P        {1,frac1} * {1,frac2}
//  out_valid      out  1        result valid; held until out_ready
//  out_ready      in   1        consumer accepts result
//  out_result     out  32       {sign, exp, frac}
//  out_overflow   out  1        result saturated to infinity
//  out_underflow  out  1        result flushed to zero
//  out_inexact    out  1        rounding discarded nonzero bits, or over/underflow
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; out_valid, out_result, all flags = 0.
//    in_ready=1 as soon as rst_n=1. Reset mid-operation aborts the transaction; no partial output.
//  - FSM IDLE -> NORM -> ROUND -> DONE -> IDLE. in_ready = (state==IDLE), combinational.
//  - IDLE, accept on in_valid&in_ready at a clk edge:
//      latch sign; exp = in_exp_sum - BIAS + 1 (11-bit signed); mant = in_mant.
//      if in_mant==0 -> DONE with out_result={sign,31'b0}, flags 0.
//  - NORM: per cycle, if mant[P-1]==0 -> mant<<=1, exp-=1; else -> ROUND (no shift that cycle).
//  - ROUND: frac = mant[P-2:P-24], G = mant[P-25], S = |mant[P-26:0].
//      up = G & (S | frac[0]). frac+1 carry-out -> frac=0, exp+=1.
//      exp >= 255 -> {sign,8'hFF,23'b0}, overflow=1, inexact=1.
//      exp <= 0   -> {sign,31'b0},       underflow=1, inexact=1 (no subnormals).
//      otherwise  -> {sign, exp[7:0], frac}, inexact = G|S.
//      Result and flags register on the ROUND->DONE edge.
//  - DONE: out_valid=1; out_result and flags stable while out_ready=0.
//      out_valid&out_ready -> IDLE, out_valid=0 next cycle. No new accept in that same cycle.
//  - Latency (accept edge to out_valid high):
//      3 + k edges, where k = leading-zero shifts;
//      1 edge for zero product.
//  - Throughput: one transaction in flight.
//  - out_result and flags keep their last value after handshake until the next DONE.
// CONFIGURATION
//  FP_NORM_LZC_EN defined:
//      NORM completes in one cycle via a leading-zero count and barrel shift (exp -= lzc).
//      Latency fixed at 3 for every nonzero product.
//  FP_NORM_LZC_EN undefined:
//      iterative 1-bit/cycle shift as above. Results and flags identical in both builds.
// TESTING
//  1) sign=0, exp_sum=254, mant=48'h900000000000 (1.5*1.5)
//       -> 32'h40100000, flags 0, latency 3.
//  2) sign=0, exp_sum=254, mant=48'h400000000000 (1.0*1.0)
//       -> one shift, 32'h3F800000, latency 4 (3 with LZC_EN).
//  3) sign=1, exp_sum=200, mant=0
//       -> 32'h80000000 after 1 edge, flags 0.
//  4) exp_sum=400, mant=48'h400000000000
//       -> 32'h7F800000, overflow=1, inexact=1.
//     exp_sum=100, same mant -> 32'h00000000, underflow=1, inexact=1.
//  5) exp_sum=254, mant=48'h800001800000 (G=1, S=0, lsb=1)
//       -> 32'h40000002, inexact=1.
//     mant=48'h800000800000 (tie, lsb=0) -> 32'h40000000, inexact=1.
//  6) hold out_ready=0 for 5 cycles
//       -> out_valid, out_result stable; in_ready=0.
//     Drop rst_n during NORM -> out_valid=0, out_result=0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/fp_mul_normalize_round.sv
// fp_mul_normalize_round: normalize, round-to-nearest-even and pack an FP multiply product.
// Define FP_NORM_LZC_EN for single-cycle leading-zero normalization instead of 1-bit/cycle shifts.
module fp_mul_normalize_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [EXP_W:0]                in_exp_sum,
    input  logic [2*(FRAC_W+1)-1:0]       in_mant,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_W+FRAC_W:0]         out_result,
    output logic                          out_overflow,
    output logic                          out_underflow,
    output logic                          out_inexact
);
    localparam int P    = 2 * (FRAC_W + 1);
    localparam int EW   = EXP_W + 3;
    localparam int W    = EXP_W + FRAC_W + 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [P-1:0]    mant_q, mant_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    result_q, result_d;
    logic            ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

    logic [FRAC_W-1:0] frac;
    logic              g, s, ovf, unf;
    logic [FRAC_W:0]   fr;
    logic [EW-1:0]     exp_r;

    assign frac  = mant_q[P-2 -: FRAC_W];
    assign g     = mant_q[P-2-FRAC_W];
    assign s     = |mant_q[P-3-FRAC_W:0];
    assign fr    = {1'b0, frac} + (FRAC_W+1)'(g & (s | frac[0]));
    assign exp_r = exp_q + EW'(fr[FRAC_W]);
    // exp_r is two's complement; the sign bit marks negative exponents
    assign ovf   = !exp_r[EW-1] && (exp_r >= EW'(EMAX));
    assign unf   = exp_r[EW-1] || (exp_r == '0);

`ifdef FP_NORM_LZC_EN
    localparam int LW = $clog2(P);
    logic [LW-1:0] lzc;
    always_comb begin
        lzc = '0;
        for (int i = 0; i < P; i++)
            if (mant_q[i]) lzc = LW'(P - 1 - i);
    end
`endif

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d = in_sign;
                exp_d  = {2'b00, in_exp_sum} - EW'(BIAS - 1);
                mant_d = in_mant;
                if (in_mant == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = {in_sign, {(W-1){1'b0}}};
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                    inx_d       = 1'b0;
                end else begin
                    state_d = NORM;
                end
            end
`ifdef FP_NORM_LZC_EN
            NORM: begin
                mant_d  = mant_q << lzc;
                exp_d   = exp_q - EW'(lzc);
                state_d = ROUND;
            end
`else
            NORM: if (mant_q[P-1]) state_d = ROUND;
                  else begin
                      mant_d = mant_q << 1;
                      exp_d  = exp_q - EW'(1);
                  end
`endif
            ROUND: begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                result_d    = ovf ? {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                            : unf ? {sign_q, {(W-1){1'b0}}}
                            : {sign_q, exp_r[EXP_W-1:0], fr[FRAC_W-1:0]};
                ovf_d       = ovf;
                unf_d       = unf;
                inx_d       = ovf | unf | g | s;
            end
            default: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_inexact   = inx_q;
endmodule
